// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and helpers for the synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    // Read-port behaviour selector for the FWFT parameter
    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Pointer width: address bits plus one wrap bit
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : Simple dual-port storage array, synchronous write,
//                asynchronous read, no reset on the contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    // Store the write word; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : fifo_ram
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with wrap-bit pointers, threshold flags,
//                sticky error flags and selectable registered / FWFT read.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_LEVEL   = FIFO_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
    localparam int c_PTR_W  = ptr_width(FIFO_DEPTH);
    // Any FWFT value other than MODE_FWFT falls back to registered reads
    localparam int c_MODE   = (FWFT == MODE_FWFT) ? MODE_FWFT : MODE_STD;

    localparam logic [c_PTR_W-1:0] c_AF = c_PTR_W'(AF_LEVEL);
    localparam logic [c_PTR_W-1:0] c_AE = c_PTR_W'(AE_LEVEL);

    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [c_PTR_W-1:0]    w_level;
    logic [DATA_WIDTH-1:0] w_head;

    // Flags come straight from the registered pointers
    assign w_full   = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                      (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_level  = r_wr_ptr - r_rd_ptr;
    // Acceptance looks only at the current flags, so a same-cycle read
    // never makes room for a write into a full FIFO (and vice versa)
    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    // Advance pointers on accepted transfers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky errors; a new error in the clearing cycle is kept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            else if (clr_err)     r_overflow  <= 1'b0;
            if (rd_en && w_empty) r_underflow <= 1'b1;
            else if (clr_err)     r_underflow <= 1'b0;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (c_ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[c_ADDR_W-1:0]),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr[c_ADDR_W-1:0]),
        .o_rd_data (w_head)
    );

    generate
        if (c_MODE == MODE_FWFT) begin : g_fwft
            // Head word is always presented; rd_en just pops it
            assign data_out   = w_head;
            assign data_valid = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;
            logic                  r_data_valid;

            // Capture the head word on an accepted read, one-cycle valid pulse
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_acc;
                    if (w_rd_acc) r_data_out <= w_head;
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign level        = w_level;
    assign almost_full  = (w_level >= c_AF);
    assign almost_empty = (w_level <= c_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo
//  Description : Directed self-checking bench for sync_fifo, one instance in
//                registered-read mode and one in FWFT mode on shared inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_DW = 8;
    localparam int c_DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en;
    logic [c_DW-1:0] data_in;
    logic            rd_en;
    logic            clr_err;

    logic [c_DW-1:0] s_dout, f_dout;
    logic            s_dv, f_dv, s_full, f_full, s_empty, f_empty;
    logic            s_af, f_af, s_ae, f_ae, s_ovf, f_ovf, s_udf, f_udf;
    logic [4:0]      s_lvl, f_lvl;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_v;
    logic [7:0] next_v;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(s_dout), .data_valid(s_dv), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .level(s_lvl),
        .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .clr_err(clr_err), .data_out(f_dout), .data_valid(f_dv), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .level(f_lvl),
        .overflow(f_ovf), .underflow(f_udf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; outputs are then settled for checking
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; idle(); data_in = '0;
        #12;
        chk("rst_level", s_lvl, 0);
        chk("rst_empty", s_empty, 1);
        chk("rst_full", s_full, 0);
        chk("rst_ae", s_ae, 1);
        chk("rst_af", s_af, 0);
        chk("rst_dv", s_dv, 0);
        chk("rst_ovf_udf", {s_ovf, s_udf}, 0);
        chk("rst_fwft_dv", f_dv, 0);
        @(posedge clk); #1; rst = 1'b0;

        // Fill with 0x01..0x10, watching level and threshold flags
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; data_in = 8'(i);
            tick();
            chk("fill_level", s_lvl, i);
            chk("fill_ae", s_ae, (i <= 2) ? 1 : 0);
            chk("fill_af", s_af, (i >= 14) ? 1 : 0);
        end
        idle();
        chk("fill_full", s_full, 1);
        chk("fill_lvl16", s_lvl, 16);

        // Drain: each word appears one cycle after its rd_en
        for (int i = 1; i <= 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_data", s_dout, i);
            chk("drain_dv", s_dv, 1);
        end
        idle();
        tick();
        chk("drain_empty", s_empty, 1);
        chk("drain_dv_off", s_dv, 0);
        chk("drain_hold", s_dout, 8'h10);
        chk("drain_no_udf", s_udf, 0);

        // Overflow: full FIFO, extra write of 0xAA must be dropped
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; data_in = 8'(8'h20 + i);
            tick();
        end
        wr_en = 1'b1; data_in = 8'hAA;
        tick();
        idle();
        chk("ovf_set", s_ovf, 1);
        chk("ovf_level", s_lvl, 16);
        clr_err = 1'b1;
        tick();
        idle();
        chk("ovf_clr", s_ovf, 0);
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            chk("ovf_data", s_dout, 8'h20 + i);
        end
        idle();
        chk("ovf_empty", s_empty, 1);

        // Underflow: simultaneous read+write on empty, read is rejected
        wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h33;
        tick();
        idle();
        chk("udf_set", s_udf, 1);
        chk("udf_level", s_lvl, 1);
        chk("udf_no_dv", s_dv, 0);
        rd_en = 1'b1;
        tick();
        idle();
        chk("udf_data", s_dout, 8'h33);
        clr_err = 1'b1;
        tick();
        idle();
        chk("udf_clr", s_udf, 0);
        rd_en = 1'b1; clr_err = 1'b1;
        tick();
        idle();
        chk("udf_set_wins", s_udf, 1);

        // Wrap: 40 cycles of read+write at level 8
        next_v = 8'h40;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; data_in = next_v; sb_q.push_back(next_v); next_v++;
            tick();
        end
        idle();
        chk("wrap_lvl8", s_lvl, 8);
        for (int i = 0; i < 40; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; data_in = next_v;
            sb_q.push_back(next_v); next_v++;
            exp_v = sb_q.pop_front();
            tick();
            chk("wrap_level", s_lvl, 8);
            chk("wrap_data", s_dout, exp_v);
        end
        idle();

        // Reach level 9 with a valid word on data_out, then async reset
        wr_en = 1'b1; data_in = next_v;
        tick();
        wr_en = 1'b1; rd_en = 1'b1; data_in = next_v + 8'd1;
        tick();
        idle();
        chk("pre_rst_lvl9", s_lvl, 9);
        chk("pre_rst_dv", s_dv, 1);
        chk("pre_rst_udf", s_udf, 1);
        #2; rst = 1'b1;
        #1;
        chk("arst_level", s_lvl, 0);
        chk("arst_empty", s_empty, 1);
        chk("arst_dv", s_dv, 0);
        chk("arst_dout", s_dout, 0);
        chk("arst_flags", {s_full, s_af, s_ae, s_ovf, s_udf}, 5'b00100);
        chk("arst_fwft_dv", f_dv, 0);
        @(posedge clk); #1; rst = 1'b0;

        // FWFT: head word shows up without any read request
        wr_en = 1'b1; data_in = 8'h5A;
        tick();
        idle();
        chk("fwft_dv", f_dv, 1);
        chk("fwft_data", f_dout, 8'h5A);
        tick();
        chk("fwft_hold", f_dout, 8'h5A);
        chk("fwft_lvl", f_lvl, 1);
        rd_en = 1'b1;
        tick();
        idle();
        chk("fwft_empty", f_empty, 1);
        chk("fwft_dv_off", f_dv, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
